// File: rtl/approx_mult_pkg.sv
// Shared types and helpers for the approximate-multiplier error sweep engine.
package approx_mult_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_LAT   = 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } sweep_state_e;

    // Unsigned |x - y|; callers zero-extend to 64 bits, so WIDTH is limited to 32.
    function automatic logic [63:0] abs_diff(input logic [63:0] x, input logic [63:0] y);
        return (x >= y) ? (x - y) : (y - x);
    endfunction

endpackage

// File: rtl/sweep_stats.sv
// Compare/accumulate stage: exact product vs. approximate product, updating
// total, correct, worst-case error distance and (with SWEEP_SUM_ED_EN) the error sum.
module sweep_stats
    import approx_mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = 2 * WIDTH + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear_i,
    input  logic                 valid_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    input  logic [2*WIDTH-1:0]   approx_y_i,
`ifdef SWEEP_SUM_ED_EN
    output logic [4*WIDTH:0]     sum_ed_o,
`endif
    output logic [CNT_W-1:0]     total_cnt_o,
    output logic [CNT_W-1:0]     correct_cnt_o,
    output logic [2*WIDTH-1:0]   max_ed_o
);

    localparam int PW = 2 * WIDTH;

    logic [PW-1:0]    exact;
    logic [PW-1:0]    ed;
    logic [CNT_W-1:0] total_q, total_d;
    logic [CNT_W-1:0] correct_q, correct_d;
    logic [PW-1:0]    max_q, max_d;

    always_comb begin
        exact     = {{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i};
        ed        = PW'(abs_diff(64'(exact), 64'(approx_y_i)));
        total_d   = total_q;
        correct_d = correct_q;
        max_d     = max_q;
        // A clear only arrives from IDLE/DONE, when no compare can be in flight.
        if (clear_i) begin
            total_d   = '0;
            correct_d = '0;
            max_d     = '0;
        end else if (valid_i) begin
            total_d = total_q + CNT_W'(1);
            if (ed == '0) begin
                correct_d = correct_q + CNT_W'(1);
            end
            if (ed > max_q) begin
                max_d = ed;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            total_q   <= '0;
            correct_q <= '0;
            max_q     <= '0;
        end else begin
            total_q   <= total_d;
            correct_q <= correct_d;
            max_q     <= max_d;
        end
    end

    assign total_cnt_o   = total_q;
    assign correct_cnt_o = correct_q;
    assign max_ed_o      = max_q;

`ifdef SWEEP_SUM_ED_EN
    localparam int SW = 4 * WIDTH + 1;

    logic [SW-1:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (clear_i) begin
            sum_d = '0;
        end else if (valid_i) begin
            sum_d = sum_q + SW'(ed);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum_ed_o = sum_q;
`endif

endmodule

// File: rtl/approx_mult_sweep_ctrl.sv
// Sweeps an operand rectangle (b inner, a outer) into an external approximate
// multiplier and collects error statistics. Define SWEEP_SUM_ED_EN for the sum_ed output.
module approx_mult_sweep_ctrl
    import approx_mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LAT   = DEF_LAT,
    parameter int CNT_W = 2 * WIDTH + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [WIDTH-1:0]     a_lo,
    input  logic [WIDTH-1:0]     a_hi,
    input  logic [WIDTH-1:0]     b_lo,
    input  logic [WIDTH-1:0]     b_hi,
    output logic [WIDTH-1:0]     op_a,
    output logic [WIDTH-1:0]     op_b,
    input  logic [2*WIDTH-1:0]   approx_y,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     total_cnt,
    output logic [CNT_W-1:0]     correct_cnt,
    output logic [2*WIDTH-1:0]   max_ed,
`ifdef SWEEP_SUM_ED_EN
    output logic [4*WIDTH:0]     sum_ed,
`endif
    output logic [1:0]           state_o
);

    localparam logic [1:0] ST_IDLE  = S_IDLE;
    localparam logic [1:0] ST_RUN   = S_RUN;
    localparam logic [1:0] ST_DRAIN = S_DRAIN;
    localparam logic [1:0] ST_DONE  = S_DONE;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] cfg_a_hi_q, cfg_b_lo_q, cfg_b_hi_q;
    logic [WIDTH-1:0] op_a_q, op_b_q;

    // Valid pipe: vld_q[i] means stage i carries an issued pair whose product
    // appears on approx_y while that pair sits in stage LAT-1. The multiplier
    // has no back-pressure, so the last stage is consumed every cycle it is valid.
    logic [LAT-1:0]   vld_q;
    logic [WIDTH-1:0] pa_q [LAT];
    logic [WIDTH-1:0] pb_q [LAT];

    logic start_ok;
    logic range_empty;
    logic issue;
    logic last_pair;
    logic pipe_live;

    assign start_ok    = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign range_empty = (a_lo > a_hi) || (b_lo > b_hi);
    assign issue       = (state_q == ST_RUN) && !abort;
    assign last_pair   = (a_q == cfg_a_hi_q) && (b_q == cfg_b_hi_q);
    assign pipe_live   = |vld_q;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_d     = a_lo;
                    b_d     = b_lo;
                    state_d = range_empty ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_DRAIN;
                end else begin
                    // Terminate on the hi compare, never on wrap, so hi = all-ones is safe.
                    if (last_pair) begin
                        state_d = ST_DRAIN;
                    end
                    if (b_q == cfg_b_hi_q) begin
                        b_d = cfg_b_lo_q;
                        a_d = a_q + WIDTH'(1);
                    end else begin
                        b_d = b_q + WIDTH'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (!pipe_live) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            cfg_a_hi_q <= '0;
            cfg_b_lo_q <= '0;
            cfg_b_hi_q <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            vld_q      <= '0;
            for (int i = 0; i < LAT; i++) begin
                pa_q[i] <= '0;
                pb_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            if (start_ok) begin
                cfg_a_hi_q <= a_hi;
                cfg_b_lo_q <= b_lo;
                cfg_b_hi_q <= b_hi;
            end
            if (issue) begin
                op_a_q  <= a_q;
                op_b_q  <= b_q;
                pa_q[0] <= a_q;
                pb_q[0] <= b_q;
            end
            vld_q[0] <= issue;
            for (int i = 1; i < LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                pa_q[i]  <= pa_q[i-1];
                pb_q[i]  <= pb_q[i-1];
            end
        end
    end

    sweep_stats #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_stats (
        .clk           (clk),
        .rst           (rst),
        .clear_i       (start_ok),
        .valid_i       (vld_q[LAT-1]),
        .a_i           (pa_q[LAT-1]),
        .b_i           (pb_q[LAT-1]),
        .approx_y_i    (approx_y),
`ifdef SWEEP_SUM_ED_EN
        .sum_ed_o      (sum_ed),
`endif
        .total_cnt_o   (total_cnt),
        .correct_cnt_o (correct_cnt),
        .max_ed_o      (max_ed)
    );

    assign op_a    = op_a_q;
    assign op_b    = op_b_q;
    assign busy    = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done    = (state_q == ST_DONE);
    assign state_o = state_q;

endmodule

// File: tb/tb_approx_mult_sweep_ctrl.sv
// Bench for approx_mult_sweep_ctrl: three instances (W4/LAT1, W16/LAT3, W4/LAT2)
// with behavioural multiplier stubs; table-driven sweeps plus corner sequences.
module tb_approx_mult_sweep_ctrl;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instance A: WIDTH=4, LAT=1, selectable error stub
  logic       a_start, a_abort;
  logic [3:0] a_alo, a_ahi, a_blo, a_bhi, a_opa, a_opb;
  logic [7:0] a_y, a_exact, a_maxed;
  logic       a_busy, a_done;
  logic [8:0] a_total, a_correct;
  logic [1:0] a_state, a_mode;
`ifdef SWEEP_SUM_ED_EN
  logic [16:0] a_sum;
`endif

  assign a_exact = {4'b0, a_opa} * {4'b0, a_opb};
  always_comb begin
    case (a_mode)
      2'd1:    a_y = a_exact & 8'hFE;
      2'd2:    a_y = a_exact ^ 8'h10;
      default: a_y = a_exact;
    endcase
  end

  approx_mult_sweep_ctrl #(.WIDTH(4), .LAT(1)) u_a (
    .clk(clk), .rst(rst), .start(a_start), .abort(a_abort),
    .a_lo(a_alo), .a_hi(a_ahi), .b_lo(a_blo), .b_hi(a_bhi),
    .op_a(a_opa), .op_b(a_opb), .approx_y(a_y),
    .busy(a_busy), .done(a_done), .total_cnt(a_total), .correct_cnt(a_correct),
    .max_ed(a_maxed),
`ifdef SWEEP_SUM_ED_EN
    .sum_ed(a_sum),
`endif
    .state_o(a_state)
  );

  // ---------------- instance B: WIDTH=16, LAT=3, exact stub with two register stages
  logic        b_start, b_abort;
  logic [15:0] b_alo, b_ahi, b_blo, b_bhi, b_opa, b_opb;
  logic [31:0] b_y, b_p1, b_maxed;
  logic        b_busy, b_done;
  logic [32:0] b_total, b_correct;
  logic [1:0]  b_state;
`ifdef SWEEP_SUM_ED_EN
  logic [64:0] b_sum;
`endif

  always_ff @(posedge clk) begin
    b_p1 <= {16'b0, b_opa} * {16'b0, b_opb};
    b_y  <= b_p1;
  end

  approx_mult_sweep_ctrl #(.WIDTH(16), .LAT(3)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .abort(b_abort),
    .a_lo(b_alo), .a_hi(b_ahi), .b_lo(b_blo), .b_hi(b_bhi),
    .op_a(b_opa), .op_b(b_opb), .approx_y(b_y),
    .busy(b_busy), .done(b_done), .total_cnt(b_total), .correct_cnt(b_correct),
    .max_ed(b_maxed),
`ifdef SWEEP_SUM_ED_EN
    .sum_ed(b_sum),
`endif
    .state_o(b_state)
  );

  // ---------------- instance C: WIDTH=4, LAT=2, exact stub with one register stage
  logic       c_start, c_abort;
  logic [3:0] c_alo, c_ahi, c_blo, c_bhi, c_opa, c_opb;
  logic [7:0] c_y, c_maxed;
  logic       c_busy, c_done;
  logic [8:0] c_total, c_correct;
  logic [1:0] c_state;
`ifdef SWEEP_SUM_ED_EN
  logic [16:0] c_sum;
`endif

  always_ff @(posedge clk) c_y <= {4'b0, c_opa} * {4'b0, c_opb};

  approx_mult_sweep_ctrl #(.WIDTH(4), .LAT(2)) u_c (
    .clk(clk), .rst(rst), .start(c_start), .abort(c_abort),
    .a_lo(c_alo), .a_hi(c_ahi), .b_lo(c_blo), .b_hi(c_bhi),
    .op_a(c_opa), .op_b(c_opb), .approx_y(c_y),
    .busy(c_busy), .done(c_done), .total_cnt(c_total), .correct_cnt(c_correct),
    .max_ed(c_maxed),
`ifdef SWEEP_SUM_ED_EN
    .sum_ed(c_sum),
`endif
    .state_o(c_state)
  );

  // ---------------- scoreboard helpers
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Each wait counts rising edges (the first one included) until done, bounded by limit.
  task automatic wait_a(input int limit, output int cyc, output bit busy_seen);
    cyc = 0;
    busy_seen = 1'b0;
    while (cyc < limit) begin
      @(posedge clk); #1;
      a_start = 1'b0; a_abort = 1'b0;
      cyc++;
      if (a_busy) busy_seen = 1'b1;
      if (a_done) break;
    end
  endtask

  task automatic wait_b(input int limit, output int cyc);
    cyc = 0;
    while (cyc < limit) begin
      @(posedge clk); #1;
      b_start = 1'b0; b_abort = 1'b0;
      cyc++;
      if (b_done) break;
    end
  endtask

  task automatic wait_c(input int limit, output int cyc);
    cyc = 0;
    while (cyc < limit) begin
      @(posedge clk); #1;
      c_start = 1'b0; c_abort = 1'b0;
      cyc++;
      if (c_done) break;
    end
  endtask

  typedef struct {
    logic [3:0] alo, ahi, blo, bhi;
    logic [1:0] mode;
    int         e_total, e_correct, e_max, e_sum, e_cyc;
    bit         e_busy;
  } vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  initial begin
    vec_t        vecs[8];
    int          cyc;
    bit          bs;
    logic [31:0] exp_pair;

    //          alo    ahi    blo    bhi    mode  tot  cor  max sum  cyc busy
    vecs[0] = '{4'd0,  4'd15, 4'd0,  4'd15, 2'd0, 256, 256, 0,  0,  259, 1'b1};
    vecs[1] = '{4'd0,  4'd15, 4'd0,  4'd15, 2'd1, 256, 192, 1,  64, 259, 1'b1};
    vecs[2] = '{4'd5,  4'd4,  4'd0,  4'd15, 2'd0, 0,   0,   0,  0,  1,   1'b0};
    vecs[3] = '{4'd3,  4'd3,  4'd2,  4'd5,  2'd0, 4,   4,   0,  0,  7,   1'b1};
    vecs[4] = '{4'd15, 4'd15, 4'd15, 4'd15, 2'd1, 1,   0,   1,  1,  4,   1'b1};
    vecs[5] = '{4'd2,  4'd3,  4'd6,  4'd7,  2'd1, 4,   3,   1,  1,  7,   1'b1};
    vecs[6] = '{4'd0,  4'd15, 4'd9,  4'd8,  2'd0, 0,   0,   0,  0,  1,   1'b0};
    vecs[7] = '{4'd3,  4'd4,  4'd5,  4'd5,  2'd2, 2,   0,   16, 32, 5,   1'b1};

    n_checks = 0;
    n_bad    = 0;
    rst = 1'b1;
    a_start = 0; a_abort = 0; a_alo = 0; a_ahi = 0; a_blo = 0; a_bhi = 0; a_mode = 0;
    b_start = 0; b_abort = 0; b_alo = 0; b_ahi = 0; b_blo = 0; b_bhi = 0;
    c_start = 0; c_abort = 0; c_alo = 0; c_ahi = 0; c_blo = 0; c_bhi = 0;

    // ---------------- reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset a_busy", 64'(a_busy), 0);
    check("reset a_done", 64'(a_done), 0);
    check("reset a_total", 64'(a_total), 0);
    check("reset a_op", 64'({a_opa, a_opb}), 0);
    check("reset b_state", 64'(b_state), 0);
    rst = 1'b0;

    // ---------------- table-driven sweeps on instance A
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      a_alo = vecs[i].alo; a_ahi = vecs[i].ahi;
      a_blo = vecs[i].blo; a_bhi = vecs[i].bhi;
      a_mode = vecs[i].mode;
      a_start = 1'b1;
      wait_a(400, cyc, bs);
      check($sformatf("v%0d done_cycle", i), 64'(cyc), 64'(vecs[i].e_cyc));
      check($sformatf("v%0d busy_seen", i), 64'(bs), 64'(vecs[i].e_busy));
      check($sformatf("v%0d total", i), 64'(a_total), 64'(vecs[i].e_total));
      check($sformatf("v%0d correct", i), 64'(a_correct), 64'(vecs[i].e_correct));
      check($sformatf("v%0d max_ed", i), 64'(a_maxed), 64'(vecs[i].e_max));
`ifdef SWEEP_SUM_ED_EN
      check($sformatf("v%0d sum_ed", i), 64'(a_sum), 64'(vecs[i].e_sum));
`endif
    end

    // ---------------- A: start pulsed mid-run with changed inputs is ignored
    @(negedge clk);
    a_alo = 0; a_ahi = 15; a_blo = 0; a_bhi = 15; a_mode = 2'd0;
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    a_ahi = 4'd0;
    a_start = 1'b1;
    wait_a(400, cyc, bs);
    check("busy_start done_cycle", 64'(cyc + 5), 259);
    check("busy_start total", 64'(a_total), 256);
    check("busy_start correct", 64'(a_correct), 256);

    // ---------------- B: WIDTH=16 near the top of the range, issue order
    @(negedge clk);
    b_alo = 16'd100; b_ahi = 16'd102; b_blo = 16'd65534; b_bhi = 16'd65535;
    b_start = 1'b1;
    for (int a = 100; a <= 102; a++) begin
      exp_q.push_back({16'(a), 16'd65534});
      exp_q.push_back({16'(a), 16'd65535});
    end
    @(posedge clk); #1;
    b_start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      exp_pair = exp_q.pop_front();
      check($sformatf("w16 op pair %0d", k), 64'({b_opa, b_opb}), 64'(exp_pair));
    end
    wait_b(40, cyc);
    check("w16 done_cycle", 64'(cyc + 7), 11);
    check("w16 total", 64'(b_total), 6);
    check("w16 correct", 64'(b_correct), 6);
    check("w16 max_ed", 64'(b_maxed), 0);
    repeat (3) @(posedge clk);
    #1;
    check("w16 op hold", 64'({b_opa, b_opb}), 64'({16'd102, 16'd65535}));
    check("w16 done level", 64'(b_done), 1);
    check("w16 total stable", 64'(b_total), 6);

    // ---------------- C: abort after 10 issued pairs, then a fresh full sweep
    @(negedge clk);
    c_alo = 0; c_ahi = 15; c_blo = 0; c_bhi = 15;
    c_start = 1'b1;
    @(posedge clk); #1;
    c_start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    c_abort = 1'b1;
    wait_c(40, cyc);
    check("abort done_cycle", 64'(cyc + 11), 14);
    check("abort total", 64'(c_total), 10);
    check("abort correct", 64'(c_correct), 10);
    check("abort busy", 64'(c_busy), 0);
    @(negedge clk);
    c_abort = 1'b1;
    @(posedge clk); #1;
    c_abort = 1'b0;
    check("abort_in_done done", 64'(c_done), 1);
    check("abort_in_done total", 64'(c_total), 10);
    @(negedge clk);
    c_start = 1'b1;
    wait_c(400, cyc);
    check("restart done_cycle", 64'(cyc), 260);
    check("restart total", 64'(c_total), 256);
    check("restart correct", 64'(c_correct), 256);

    // ---------------- C: synchronous reset mid-run discards everything
    @(negedge clk);
    c_start = 1'b1;
    @(posedge clk); #1;
    c_start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst op", 64'({c_opa, c_opb}), 0);
    check("rst busy", 64'(c_busy), 0);
    check("rst done", 64'(c_done), 0);
    check("rst total", 64'(c_total), 0);
    check("rst correct", 64'(c_correct), 0);
    check("rst max_ed", 64'(c_maxed), 0);
    check("rst state", 64'(c_state), 0);
`ifdef SWEEP_SUM_ED_EN
    check("rst sum_ed", 64'(c_sum), 0);
`endif
    repeat (5) @(posedge clk);
    #1;
    check("rst stays idle", 64'({c_busy, c_done}), 0);
    check("rst no progress", 64'(c_total), 0);

    // ---------------- C: start and abort together in IDLE, start wins
    @(negedge clk);
    c_alo = 0; c_ahi = 0; c_blo = 0; c_bhi = 1;
    c_start = 1'b1;
    c_abort = 1'b1;
    wait_c(40, cyc);
    check("start_abort done_cycle", 64'(cyc), 6);
    check("start_abort total", 64'(c_total), 2);
    check("start_abort correct", 64'(c_correct), 2);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/approx_mult_sweep_ctrl.md
Name: approx_mult_sweep_ctrl

Overview:
Hardware error-characterisation sequencer for the recursive approximate multipliers (e.g. n16_5).
- Sweeps a configured rectangle of operand space, one operand pair per clock, into an external approximate multiplier under test.
- Compares each approximate product against an internal exact product.
- Accumulates total, correct and worst-case error-distance statistics.
- Replaces exhaustive simulation sweeps with an FPGA-resident engine; a host or wrapper reads the results after done.

Parameters:
WIDTH, 16, operand width; product width is 2*WIDTH
LAT, 1, clocks from op_a/op_b registered to approx_y valid (>=1)
CNT_W, 2*WIDTH+1, counter width; must hold (2^WIDTH)^2 for a full sweep

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; begin sweep (honoured only in IDLE or DONE)
abort  in  1  stop issuing, drain, go to DONE with partial results
a_lo  in  WIDTH  first a value (inclusive)
a_hi  in  WIDTH  last a value (inclusive)
b_lo  in  WIDTH  first b value (inclusive)
b_hi  in  WIDTH  last b value (inclusive)
op_a  out  WIDTH  operand a to multiplier under test (registered)
op_b  out  WIDTH  operand b to multiplier under test (registered)
approx_y  in  2*WIDTH  product from multiplier under test
busy  out  1  high in RUN and DRAIN
done  out  1  level, high in DONE until next accepted start or rst
total_cnt  out  CNT_W  pairs compared
correct_cnt  out  CNT_W  pairs with approx_y == a*b
max_ed  out  2*WIDTH  max |a*b - approx_y| seen

Behaviour:
- Reset: the sync rst is the only reset. All outputs go to 0; FSM goes to IDLE; valid pipe is cleared. rst mid-sweep discards all progress.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE on start:
  - Latch a_lo..b_hi into config registers; input changes after this are ignored.
  - Clear the counters and max_ed.
  - If a_lo>a_hi or b_lo>b_hi, go directly to DONE with zero counts.
  - Otherwise go to RUN.
- start while busy is ignored.
- RUN issue order: b is the inner loop, a the outer loop, starting at (a_lo,b_lo).
  - Each cycle: register op_a/op_b and push a valid bit plus a copy of the operands into a LAT-deep pipe.
  - Advance: if b==b_hi then b<=b_lo and a<=a+1, else b<=b+1.
  - After issuing (a_hi,b_hi), go to DRAIN. No wrap-around is used; compare against hi, so a_hi = 2^WIDTH-1 terminates correctly.
- abort in RUN: no further issue; go to DRAIN. Pairs already in the pipe are still counted.
- abort in IDLE, DRAIN or DONE is ignored.
- Compare stage (pipe output valid):
  - exact = delayed_a*delayed_b (2*WIDTH, unsigned).
  - ed = |exact - approx_y|.
  - total_cnt+=1; correct_cnt+=1 if ed==0; max_ed<=max(max_ed,ed).
- DRAIN: wait until the pipe is empty (LAT cycles after the last issue), then go to DONE.
- Latency: the first compare occurs LAT cycles after the first issue. A full WIDTH=16 sweep takes 2^32 + LAT + 2 cycles.
- Stability: op_a/op_b hold their last value outside RUN. Result outputs are stable in DONE.
- Simultaneous start+abort in IDLE: start wins. rst overrides everything.

Optional Feature:
SWEEP_SUM_ED_EN
- Defined: adds output sum_ed [4*WIDTH+1-1:0], an accumulated sum of ed, cleared on accepted start. The host divides by total_cnt for MED.
- Not defined: the port and accumulator are absent; all other behaviour is identical.

Decomposition:
- Package approx_mult_pkg holds:
  - FSM state enum (IDLE, RUN, DRAIN, DONE).
  - Default WIDTH/LAT constants.
  - A function for unsigned absolute difference.
- One natural sub-module, sweep_stats: the compare/accumulate stage. Inputs: valid, delayed a, delayed b, approx_y, clear. Outputs: the counters, max_ed and optional sum_ed.
- The controller holds the FSM, address counters and valid pipe.

Test Plan:
- WIDTH=4, LAT=1, exact stub (approx_y=a*b), full range 0..15 -> total_cnt=256, correct_cnt=256, max_ed=0, done rises 259 cycles after start.
- WIDTH=4, stub forces product bit0=0, full range -> total=256, correct=192 (odd*odd pairs = 64 wrong), max_ed=1, sum_ed=64 with SWEEP_SUM_ED_EN.
- WIDTH=16, LAT=3, a 100..102, b 65534..65535, exact stub -> total=6; op order (100,65534),(100,65535),(101,65534)...; no wrap hang at 65535.
- Empty range a_lo=5, a_hi=4 -> done next cycle, total=0, busy never high.
- abort 10 cycles into a 256-pair run with LAT=2 -> total=10 (all issued pairs drained), done high, a second start gives a fresh full count.
- rst asserted mid-RUN, plus start pulsed while busy -> rst: all outputs 0, IDLE; start during busy has no effect on counts.
